// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline-stage register, 1-cycle latency; SKID=1 gives a 2-entry skid with registered in_ready, SKID=0 a single register with in_ready = !valid | out_ready.
// Optional stall counter under `ifdef PIPE_STATS_EN; flush kills held entries, out_ctrl is zero on bubbles.
module pipe_stage_reg #(
    parameter int DATA_W   = 32,
    parameter int NUM_DATA = 2,
    parameter int CTRL_W   = 4,
    parameter int ADDR_W   = 4,
    parameter int SKID     = 1
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [ADDR_W-1:0]          in_waddr,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [ADDR_W-1:0]          out_waddr,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [1:0]                 occupancy
`ifdef PIPE_STATS_EN
    ,
    input  logic                       stats_clr,
    output logic [15:0]                stall_cnt
`endif
);

    typedef struct packed {
        logic [CTRL_W-1:0]          ctrl;
        logic [ADDR_W-1:0]          waddr;
        logic [NUM_DATA*DATA_W-1:0] data;
    } entry_t;

    entry_t     w_in;
    entry_t     w_m;
    logic       w_m_vld;
    logic       w_in_rdy;
    logic       w_in_fire;
    logic       w_out_fire;
    logic [1:0] w_occ;

    assign w_in.ctrl  = in_ctrl;
    assign w_in.waddr = in_waddr;
    assign w_in.data  = in_data;

    assign w_in_fire  = in_valid & w_in_rdy;
    assign w_out_fire = w_m_vld & out_ready;

    assign in_ready  = w_in_rdy;
    assign out_valid = w_m_vld;
    assign out_ctrl  = w_m_vld ? w_m.ctrl : '0;
    assign out_waddr = w_m.waddr;
    assign out_data  = w_m.data;
    assign occupancy = w_occ;

    generate
        if (SKID != 0) begin : g_skid
            typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

            state_t r_state;
            entry_t r_m;
            entry_t r_s;
            logic   r_in_rdy;

            // r_in_rdy tracks the next state so in_ready never depends on out_ready combinationally.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    r_state  <= ST_EMPTY;
                    r_m      <= '0;
                    r_s      <= '0;
                    r_in_rdy <= 1'b1;
                end else if (flush) begin
                    r_state  <= ST_EMPTY;
                    r_m.ctrl <= '0;
                    r_s.ctrl <= '0;
                    r_in_rdy <= 1'b1;
                end else begin
                    case (r_state)
                        ST_EMPTY: begin
                            if (w_in_fire) begin
                                r_m     <= w_in;
                                r_state <= ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (w_in_fire && w_out_fire) begin
                                r_m <= w_in;
                            end else if (w_out_fire) begin
                                r_state <= ST_EMPTY;
                            end else if (w_in_fire) begin
                                r_s      <= w_in;
                                r_state  <= ST_TWO;
                                r_in_rdy <= 1'b0;
                            end
                        end
                        ST_TWO: begin
                            if (w_out_fire) begin
                                r_m      <= r_s;
                                r_state  <= ST_ONE;
                                r_in_rdy <= 1'b1;
                            end
                        end
                        default: begin
                            r_state  <= ST_EMPTY;
                            r_in_rdy <= 1'b1;
                        end
                    endcase
                end
            end

            assign w_m      = r_m;
            assign w_m_vld  = (r_state != ST_EMPTY);
            assign w_in_rdy = r_in_rdy;
            assign w_occ    = (r_state == ST_TWO) ? 2'd2 :
                              (r_state == ST_ONE) ? 2'd1 : 2'd0;
        end else begin : g_single
            entry_t r_m;
            logic   r_m_vld;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    r_m     <= '0;
                    r_m_vld <= 1'b0;
                end else if (flush) begin
                    r_m.ctrl <= '0;
                    r_m_vld  <= 1'b0;
                end else if (w_in_fire) begin
                    r_m     <= w_in;
                    r_m_vld <= 1'b1;
                end else if (w_out_fire) begin
                    r_m_vld <= 1'b0;
                end
            end

            assign w_m      = r_m;
            assign w_m_vld  = r_m_vld;
            assign w_in_rdy = !r_m_vld | out_ready;
            assign w_occ    = {1'b0, r_m_vld};
        end
    endgenerate

`ifdef PIPE_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_stall_cnt <= '0;
        end else if (stats_clr) begin
            r_stall_cnt <= '0;
        end else if (w_m_vld && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: SKID=1 instance u_dut, SKID=0 instance u_dut0 with a scoreboard.
module tb_pipe_stage_reg;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RST_N;
    int   checks = 0;
    int   errors = 0;

    logic        flush, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  in_ctrl, in_waddr, out_ctrl, out_waddr;
    logic [63:0] in_data, out_data;
    logic [1:0]  occupancy;

    logic        flush0, in_valid0, in_ready0, out_valid0, out_ready0;
    logic [3:0]  in_ctrl0, in_waddr0, out_ctrl0, out_waddr0;
    logic [63:0] in_data0, out_data0;
    logic [1:0]  occupancy0;

`ifdef PIPE_STATS_EN
    logic        stats_clr, stats_clr0;
    logic [15:0] stall_cnt, stall_cnt0;
`endif

    pipe_stage_reg #(.SKID(1)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_waddr(in_waddr), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_waddr(out_waddr), .out_data(out_data), .occupancy(occupancy)
`ifdef PIPE_STATS_EN
        , .stats_clr(stats_clr), .stall_cnt(stall_cnt)
`endif
    );

    pipe_stage_reg #(.SKID(0)) u_dut0 (
        .CLK(CLK), .RST_N(RST_N), .flush(flush0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_ctrl(in_ctrl0),
        .in_waddr(in_waddr0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_ctrl(out_ctrl0),
        .out_waddr(out_waddr0), .out_data(out_data0), .occupancy(occupancy0)
`ifdef PIPE_STATS_EN
        , .stats_clr(stats_clr0), .stall_cnt(stall_cnt0)
`endif
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        in_valid = 1'b1; in_ctrl = 4'b1011; in_waddr = 4'h3;
        in_data = {32'hDEAD_BEEF, 32'h0000_0010}; out_ready = 1'b1;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (out_ctrl !== 4'h0) begin errors++; $display("FAIL rst_out_ctrl got %h exp 0", out_ctrl); end
        checks++; if (out_waddr !== 4'h0) begin errors++; $display("FAIL rst_out_waddr got %h exp 0", out_waddr); end
        checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL rst_out_data got %h exp 0", out_data); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rst_occupancy got %0d exp 0", occupancy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL rst_in_ready0 got %b exp 1", in_ready0); end
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL rst_out_valid0 got %b exp 0", out_valid0); end
        RST_N = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_out_valid got %b exp 1", out_valid); end
        checks++; if (out_ctrl !== 4'b1011) begin errors++; $display("FAIL first_out_ctrl got %b exp 1011", out_ctrl); end
        checks++; if (out_waddr !== 4'h3) begin errors++; $display("FAIL first_out_waddr got %h exp 3", out_waddr); end
        checks++; if (out_data !== {32'hDEAD_BEEF, 32'h0000_0010}) begin errors++; $display("FAIL first_out_data got %h exp deadbeef00000010", out_data); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_out_valid got %b exp 0", out_valid); end
        checks++; if (out_ctrl !== 4'h0) begin errors++; $display("FAIL bubble_out_ctrl got %h exp 0", out_ctrl); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 64'(i); in_ctrl = 4'hA; in_waddr = 4'(i);
            tick();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b exp 1", i, out_valid); end
            checks++; if (out_data !== 64'(i)) begin errors++; $display("FAIL b2b_data[%0d] got %0d exp %0d", i, out_data, i); end
            checks++; if (out_waddr !== 4'(i)) begin errors++; $display("FAIL b2b_waddr[%0d] got %0d exp %0d", i, out_waddr, i); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got %b exp 1", i, in_ready); end
            checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL b2b_occ[%0d] got %0d exp 1", i, occupancy); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_ctrl = 4'h5;
        in_valid = 1'b1; in_data = 64'd100; tick();
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL bp_occ1 got %0d exp 1", occupancy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_rdy1 got %b exp 1", in_ready); end
        in_data = 64'd101; tick();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_occ2 got %0d exp 2", occupancy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_rdy2 got %b exp 0", in_ready); end
        in_data = 64'd102; tick();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_occ_hold got %0d exp 2", occupancy); end
        checks++; if (out_data !== 64'd100 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_out got %0d/%b exp 100/1", out_data, out_valid); end
        out_ready = 1'b1; tick();
        checks++; if (out_data !== 64'd101 || occupancy !== 2'd1) begin errors++; $display("FAIL bp_out1 got %0d occ %0d exp 101 occ 1", out_data, occupancy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_rdy_back got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_data !== 64'd102 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_out2 got %0d/%b exp 102/1", out_data, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL bp_empty got %b occ %0d exp 0 occ 0", out_valid, occupancy); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_ctrl = 4'hF;
        in_valid = 1'b1; in_data = 64'd200; tick();
        flush = 1'b1; in_data = 64'd201; tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL fl1_kill got %b occ %0d exp 0 occ 0", out_valid, occupancy); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl1_discard got %b exp 0", out_valid); end
        in_valid = 1'b1; in_data = 64'd210; tick();
        in_data = 64'd211; tick();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL fl2_occ got %0d exp 2", occupancy); end
        flush = 1'b1; in_data = 64'd212; tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl2_valid got %b exp 0", out_valid); end
        checks++; if (out_ctrl !== 4'h0) begin errors++; $display("FAIL fl2_ctrl got %h exp 0", out_ctrl); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL fl2_occ0 got %0d exp 0", occupancy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fl2_in_ready got %b exp 1", in_ready); end
        checks++; if (out_data !== 64'd210) begin errors++; $display("FAIL fl2_data_kept got %0d exp 210", out_data); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl2_discard got %b exp 0", out_valid); end
        in_valid = 1'b1; in_data = 64'd213; tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 64'd213) begin errors++; $display("FAIL fl2_recover got %b/%0d exp 1/213", out_valid, out_data); end
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 64'd300; tick();
        in_data = 64'd301; tick();
        in_valid = 1'b0;
        #2 RST_N = 1'b0;
        #1;
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL arst_clear got occ %0d valid %b exp 0/0", occupancy, out_valid); end
        checks++; if (in_ready !== 1'b1 || out_data !== 64'h0) begin errors++; $display("FAIL arst_rdy_data got %b/%h exp 1/0", in_ready, out_data); end
        tick();
        RST_N = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_after got %b exp 0", out_valid); end
    endtask

    task automatic test_skid0_random();
        logic [31:0] nv;
        logic [31:0] q[$];
        logic [31:0] e;
        int sent, recv;
        nv = 32'd1; sent = 0; recv = 0;
        for (int c = 0; c < 1006; c++) begin
            in_valid0  = (c < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            out_ready0 = (c < 1000) ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data0 = {~nv, nv}; in_ctrl0 = nv[3:0]; in_waddr0 = nv[7:4];
            @(negedge CLK);
            checks++; if (in_ready0 !== (!out_valid0 | out_ready0)) begin errors++; $display("FAIL s0_in_ready c%0d got %b exp %b", c, in_ready0, !out_valid0 | out_ready0); end
            if (out_valid0 && out_ready0) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL s0_spurious c%0d got %h exp none", c, out_data0);
                end else begin
                    e = q.pop_front();
                    recv++;
                    if (out_data0 !== {~e, e} || out_ctrl0 !== e[3:0] || out_waddr0 !== e[7:4]) begin
                        errors++; $display("FAIL s0_entry c%0d got %h/%h/%h exp %h/%h/%h", c, out_data0, out_ctrl0, out_waddr0, {~e, e}, e[3:0], e[7:4]);
                    end
                end
            end else if (!out_valid0) begin
                checks++; if (out_ctrl0 !== 4'h0) begin errors++; $display("FAIL s0_bubble_ctrl c%0d got %h exp 0", c, out_ctrl0); end
            end
            if (in_valid0 && in_ready0) begin
                q.push_back(nv);
                nv = nv + 32'd1;
                sent++;
            end
            @(posedge CLK);
            #1;
        end
        in_valid0 = 1'b0;
        checks++; if (q.size() != 0 || recv != sent) begin errors++; $display("FAIL s0_drain got recv %0d left %0d exp recv %0d left 0", recv, q.size(), sent); end
        checks++; if (sent < 100) begin errors++; $display("FAIL s0_traffic got %0d exp >=100", sent); end
    endtask

`ifdef PIPE_STATS_EN
    task automatic test_stats();
        stats_clr = 1'b1; tick();
        stats_clr = 1'b0;
        checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL st_clr0 got %h exp 0", stall_cnt); end
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'd400; tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL st_three got %0d exp 3", stall_cnt); end
        repeat (70000) tick();
        checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL st_sat got %h exp ffff", stall_cnt); end
        stats_clr = 1'b1; tick();
        stats_clr = 1'b0;
        checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL st_clr got %h exp 0", stall_cnt); end
        out_ready = 1'b1; tick();
    endtask
`endif

    initial begin
        RST_N = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_waddr = '0; in_data = '0;
        flush0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0;
        in_ctrl0 = '0; in_waddr0 = '0; in_data0 = '0;
`ifdef PIPE_STATS_EN
        stats_clr = 1'b0; stats_clr0 = 1'b0;
`endif
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_skid0_random();
`ifdef PIPE_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
